// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-stage front end.
// Registers one decoded instruction per handshake into a two-entry elastic
// buffer (head + skid), decodes aluop/funct into the ALU op code, and selects
// and extends the operands. The head entry drives the ALU inputs directly.
// Optional build macro: ALU_ISSUE_FORWARD_EN enables result forwarding at accept.
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | no entry held, out_valid low
// ONE   | head entry valid, skid entry unused
// FULL  | head and skid both valid, in_ready low
module alu_issue_stage #(
    parameter int W     = 32,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [W-1:0]     rs_val,
    input  logic [W-1:0]     rt_val,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    input  logic [IMM_W-1:0] imm,
    input  logic             alusrc,
    input  logic [4:0]       dest,
    input  logic             flush,
    input  logic             res_valid,
    input  logic [4:0]       res_dest,
    input  logic [W-1:0]     res_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [2:0]       alu_op,
    output logic [4:0]       out_dest,
    output logic             illegal
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [1:0]   state;

    logic [W-1:0] head_a;
    logic [W-1:0] head_b;
    logic [2:0]   head_op;
    logic [4:0]   head_dest;
    logic         head_ill;

    logic [W-1:0] skid_a;
    logic [W-1:0] skid_b;
    logic [2:0]   skid_op;
    logic [4:0]   skid_dest;
    logic         skid_ill;

    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic [W-1:0] ext_imm;
    logic [W-1:0] new_a;
    logic [W-1:0] new_b;
    logic [2:0]   new_op;
    logic         new_ill;

    logic         accept;
    logic         pop;

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign alu_a    = head_a;
    assign alu_b    = head_b;
    assign alu_op   = head_op;
    assign out_dest = head_dest;
    assign illegal  = head_ill;

    // Decode aluop/funct into the ALU op; unknown R-type funct flags illegal.
    always_comb begin
        new_op  = OP_ADD;
        new_ill = 1'b0;
        case (aluop)
            2'b00: new_op = OP_ADD;
            2'b01: new_op = OP_SUB;
            2'b11: new_op = OP_OR;
            default: begin
                case (funct)
                    6'b100000, 6'b100001: new_op = OP_ADD;
                    6'b100010, 6'b100011: new_op = OP_SUB;
                    6'b100100:            new_op = OP_AND;
                    6'b100101:            new_op = OP_OR;
                    6'b101010:            new_op = OP_SLT;
                    default: begin
                        new_op  = OP_ADD;
                        new_ill = 1'b1;
                    end
                endcase
            end
        endcase
    end

`ifdef ALU_ISSUE_FORWARD_EN
    // Replace register values with the retiring result; register 0 is never forwarded.
    always_comb begin
        src_a = rs_val;
        src_b = rt_val;
        if (res_valid && (res_dest != 5'd0) && (res_dest == rs_addr))
            src_a = res_data;
        if (res_valid && (res_dest != 5'd0) && (res_dest == rt_addr))
            src_b = res_data;
    end
`else
    logic fwd_unused;
    assign fwd_unused = ^{res_valid, res_dest, res_data, rs_addr, rt_addr};

    // Forwarding disabled: operands come straight from the register file.
    always_comb begin
        src_a = rs_val;
        src_b = rt_val;
    end
`endif

    // Operand selection; ori zero-extends its immediate, everything else sign-extends.
    always_comb begin
        if (aluop == 2'b11)
            ext_imm = {{(W-IMM_W){1'b0}}, imm};
        else
            ext_imm = {{(W-IMM_W){imm[IMM_W-1]}}, imm};
        new_a = src_a;
        new_b = alusrc ? ext_imm : src_b;
    end

    // Occupancy state machine.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state <= ONE;
                ONE: begin
                    if (accept && !pop)
                        state <= FULL;
                    else if (pop && !accept)
                        state <= EMPTY;
                end
                FULL: if (pop) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    // Head entry: loaded from the new instruction or promoted from the skid entry.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head_a    <= '0;
            head_b    <= '0;
            head_op   <= OP_ADD;
            head_dest <= '0;
            head_ill  <= 1'b0;
        end else if ((state == EMPTY && accept) || (state == ONE && accept && pop)) begin
            head_a    <= new_a;
            head_b    <= new_b;
            head_op   <= new_op;
            head_dest <= dest;
            head_ill  <= new_ill;
        end else if (state == FULL && pop) begin
            head_a    <= skid_a;
            head_b    <= skid_b;
            head_op   <= skid_op;
            head_dest <= skid_dest;
            head_ill  <= skid_ill;
        end
    end

    // Skid entry: captures an accept that arrives while the head is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            skid_a    <= '0;
            skid_b    <= '0;
            skid_op   <= OP_ADD;
            skid_dest <= '0;
            skid_ill  <= 1'b0;
        end else if (state == ONE && accept && !pop) begin
            skid_a    <= new_a;
            skid_b    <= new_b;
            skid_op   <= new_op;
            skid_dest <= dest;
            skid_ill  <= new_ill;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed checks with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_alu_issue_stage;
    localparam int W     = 32;
    localparam int IMM_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       aluop;
    logic [5:0]       funct;
    logic [W-1:0]     rs_val;
    logic [W-1:0]     rt_val;
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic [IMM_W-1:0] imm;
    logic             alusrc;
    logic [4:0]       dest;
    logic             flush;
    logic             res_valid;
    logic [4:0]       res_dest;
    logic [W-1:0]     res_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [2:0]       alu_op;
    logic [4:0]       out_dest;
    logic             illegal;

    alu_issue_stage #(.W(W), .IMM_W(IMM_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm), .alusrc(alusrc),
        .dest(dest), .flush(flush), .res_valid(res_valid), .res_dest(res_dest),
        .res_data(res_data), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_dest(out_dest),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [4:0]   dest;
        logic         ill;
    } ent_t;

    ent_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   chk_en      = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the entry offered right now must look like once buffered.
    function automatic ent_t model_entry();
        ent_t         e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        ra = rs_val;
        rb = rt_val;
`ifdef ALU_ISSUE_FORWARD_EN
        if (res_valid && res_dest != 0 && res_dest == rs_addr) ra = res_data;
        if (res_valid && res_dest != 0 && res_dest == rt_addr) rb = res_data;
`endif
        e.a    = ra;
        e.b    = !alusrc ? rb : (aluop == 2'b11 ? W'(imm) : W'($signed(imm)));
        e.dest = dest;
        e.ill  = 1'b0;
        e.op   = 3'b000;
        if (aluop == 2'b00)      e.op = 3'b000;
        else if (aluop == 2'b01) e.op = 3'b011;
        else if (aluop == 2'b11) e.op = 3'b010;
        else if (funct == 6'h20 || funct == 6'h21) e.op = 3'b000;
        else if (funct == 6'h22 || funct == 6'h23) e.op = 3'b011;
        else if (funct == 6'h24) e.op = 3'b100;
        else if (funct == 6'h25) e.op = 3'b010;
        else if (funct == 6'h2a) e.op = 3'b111;
        else e.ill = 1'b1;
        return e;
    endfunction

    // One clock: update the model at the edge, return on the following falling edge.
    task automatic step();
        bit   acc;
        bit   pp;
        ent_t e;
        @(posedge clk);
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            pp  = (q.size() > 0) && out_ready;
            e   = model_entry();
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; res_valid = 1'b0;
    endtask

    task automatic offer(input logic [1:0] op2, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic src, input logic [IMM_W-1:0] im, input logic [4:0] d);
        in_valid = 1'b1; aluop = op2; funct = fn; rs_val = a; rt_val = b;
        alusrc = src; imm = im; dest = d;
    endtask

    // Per-cycle compare of the DUT against the model queue.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", W'(out_valid), W'(q.size() != 0));
            chk("in_ready", W'(in_ready), W'(q.size() != 2));
            if (q.size() != 0) begin
                chk("alu_a", alu_a, q[0].a);
                chk("alu_b", alu_b, q[0].b);
                chk("alu_op", W'(alu_op), W'(q[0].op));
                chk("out_dest", W'(out_dest), W'(q[0].dest));
                chk("illegal", W'(illegal), W'(q[0].ill));
            end
        end
    end

    logic [5:0] legal[7] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; aluop = 2'b00; funct = 6'h0;
        rs_val = '0; rt_val = '0; rs_addr = '0; rt_addr = '0; imm = '0;
        alusrc = 1'b0; dest = '0; flush = 1'b0; res_valid = 1'b0;
        res_dest = '0; res_data = '0; out_ready = 1'b1;
        @(negedge clk);
        step();
        step();
        chk_en = 1'b1;
        chk("rst out_valid", W'(out_valid), 0);
        chk("rst in_ready", W'(in_ready), 1);
        chk("rst alu_a", alu_a, 0);
        chk("rst alu_b", alu_b, 0);
        chk("rst alu_op", W'(alu_op), 0);
        chk("rst out_dest", W'(out_dest), 0);
        chk("rst illegal", W'(illegal), 0);
        rst_n = 1'b1;

        // R-type sub
        offer(2'b10, 6'b100010, 7, 3, 1'b0, 16'h0, 5'd9);
        step();
        chk("t1 out_valid", W'(out_valid), 1);
        chk("t1 alu_a", alu_a, 7);
        chk("t1 alu_b", alu_b, 3);
        chk("t1 alu_op", W'(alu_op), 3'b011);
        chk("t1 out_dest", W'(out_dest), 9);
        idle();
        step();

        // immediate extension
        offer(2'b00, 6'h0, 1, 2, 1'b1, 16'hFFFC, 5'd1);
        step();
        chk("t2 sext", alu_b, 32'hFFFFFFFC);
        chk("t2 add", W'(alu_op), 3'b000);
        offer(2'b11, 6'h0, 1, 2, 1'b1, 16'hFFFC, 5'd2);
        step();
        chk("t2 zext", alu_b, 32'h0000FFFC);
        chk("t2 or", W'(alu_op), 3'b010);
        idle();
        step();

        // back-pressure: slt, and, or
        out_ready = 1'b0;
        offer(2'b10, 6'b101010, 10, 11, 1'b0, 0, 5'd3);
        step();
        chk("t3 ready after 1", W'(in_ready), 1);
        offer(2'b10, 6'b100100, 12, 13, 1'b0, 0, 5'd4);
        step();
        chk("t3 ready after 2", W'(in_ready), 0);
        chk("t3 head slt", W'(alu_op), 3'b111);
        offer(2'b11, 6'h0, 14, 15, 1'b0, 0, 5'd5);
        step();
        chk("t3 stall hold", W'(alu_op), 3'b111);
        out_ready = 1'b1;
        step();
        chk("t3 second and", W'(alu_op), 3'b100);
        chk("t3 ready again", W'(in_ready), 1);
        step();
        chk("t3 third or", W'(alu_op), 3'b010);
        chk("t3 or dest", W'(out_dest), 5);
        idle();
        step();
        chk("t3 drained", W'(out_valid), 0);

        // illegal funct
        offer(2'b10, 6'b000000, 1, 1, 1'b0, 0, 5'd6);
        step();
        chk("t4 illegal", W'(illegal), 1);
        chk("t4 op", W'(alu_op), 0);
        offer(2'b10, 6'b100000, 1, 1, 1'b0, 0, 5'd7);
        step();
        chk("t4 legal", W'(illegal), 0);
        idle();
        step();

        // flush while FULL with a concurrent offer
        out_ready = 1'b0;
        offer(2'b01, 6'h0, 21, 22, 1'b0, 0, 5'd8);
        step();
        offer(2'b01, 6'h0, 23, 24, 1'b0, 0, 5'd9);
        step();
        chk("t5 full", W'(in_ready), 0);
        offer(2'b00, 6'h0, 25, 26, 1'b0, 0, 5'd10);
        flush = 1'b1;
        step();
        chk("t5 out_valid", W'(out_valid), 0);
        chk("t5 in_ready", W'(in_ready), 1);
        chk("t5 alu_a zero", alu_a, 0);
        idle();
        out_ready = 1'b1;
        step();
        chk("t5 nothing appears", W'(out_valid), 0);

        // forwarding
        offer(2'b00, 6'h0, 1, 2, 1'b0, 0, 5'd11);
        rs_addr = 5'd5; res_valid = 1'b1; res_dest = 5'd5; res_data = 99;
        step();
`ifdef ALU_ISSUE_FORWARD_EN
        chk("t6 forwarded", alu_a, 99);
`else
        chk("t6 no forward", alu_a, 1);
`endif
        rs_addr = 5'd0; res_dest = 5'd0;
        step();
        chk("t6 reg0", alu_a, 1);
        idle();
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            aluop     = 2'($urandom_range(0, 3));
            funct     = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 6)] : 6'($urandom);
            rs_val    = $urandom;
            rt_val    = $urandom;
            rs_addr   = 5'($urandom_range(0, 3));
            rt_addr   = 5'($urandom_range(0, 3));
            imm       = 16'($urandom);
            alusrc    = 1'($urandom_range(0, 1));
            dest      = 5'($urandom);
            res_valid = 1'($urandom_range(0, 1));
            res_dest  = 5'($urandom_range(0, 3));
            res_data  = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            rst_n     = ($urandom_range(0, 150) != 0);
            step();
        end
        rst_n = 1'b1;
        idle();
        step();

        rst_n = 1'b0;
        step();
        chk("final rst alu_b", alu_b, 0);
        chk("final rst valid", W'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-stage front end: registers one decoded instruction per handshake, converts aluop/funct into the 3-bit ALU operation code, and selects and extends the operands.
- Presents alu_a, alu_b and alu_op directly to the ALU's a, b and op inputs.
- Two-entry elastic buffer (main + skid), so decode back-pressure never drops an instruction.

Parameters:
- W, 32, datapath width; equals the ALU operand width.
- IMM_W, 16, immediate width; extended to W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- aluop  in  2  00=add (lw/sw/addi), 01=sub (beq), 10=R-type (use funct), 11=or (ori).
- funct  in  6  R-type function field.
- rs_val  in  W  register-file rs value.
- rt_val  in  W  register-file rt value.
- rs_addr  in  5  rs index; used for forwarding.
- rt_addr  in  5  rt index; used for forwarding.
- imm  in  IMM_W  instruction immediate.
- alusrc  in  1  1 = operand b comes from the immediate.
- dest  in  5  destination register index.
- flush  in  1  discard all buffered entries.
- res_valid  in  1  retiring ALU result is valid (forwarding).
- res_dest  in  5  destination index of the retiring result.
- res_data  in  W  retiring ALU result value.
- out_valid  out  1  alu_a/alu_b/alu_op/out_dest are valid.
- out_ready  in  1  downstream consumes the head entry.
- alu_a  out  W  ALU operand a.
- alu_b  out  W  ALU operand b.
- alu_op  out  3  ALU op: 000 add, 011 sub, 100 and, 010 or, 111 slt.
- out_dest  out  5  destination index travelling with the operation.
- illegal  out  1  head entry had an undecodable funct.

Behaviour:
- Reset (rst_n low at an edge): state EMPTY; out_valid=0; alu_a=0; alu_b=0; alu_op=000; out_dest=0; illegal=0; in_ready=1 from the first edge onward.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (state != FULL), driven purely from state; no combinational path from out_ready.
- States and transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept without pop -> FULL; pop without accept -> EMPTY; accept and pop together -> ONE, new entry becomes the head.
  - FULL: pop -> ONE, skid entry moves to the head; no accept is possible.
- Latency: 1 cycle from accept to out_valid when the stage was EMPTY. Order is strictly FIFO.
- Head outputs hold stable while out_valid && !out_ready.
- Decode, evaluated at accept time and stored per entry:
  - aluop 00 -> 000; 01 -> 011; 11 -> 010.
  - aluop 10 by funct: 100000/100001 -> 000; 100010/100011 -> 011; 100100 -> 100; 100101 -> 010; 101010 -> 111.
  - Any other funct: alu_op=000 and illegal=1 for that entry.
- Operands:
  - alu_a = rs_val.
  - alu_b = rt_val when alusrc=0.
  - When alusrc=1: zero-extended imm if aluop=11, otherwise sign-extended imm.
- flush:
  - At the edge it is sampled high, state -> EMPTY and out_valid -> 0; head data outputs reset to zero.
  - An in_valid in the same cycle is dropped.
  - A pop in the same cycle is still counted by downstream; the stage does not care.
- rst_n low mid-operation behaves exactly like reset, regardless of flush or handshakes.

Optional Feature:
- Macro: ALU_ISSUE_FORWARD_EN.
- Defined:
  - At accept, if res_valid && res_dest!=0 && res_dest==rs_addr, rs_val is replaced by res_data.
  - Likewise for rt_val when res_dest==rt_addr; rt replacement applies before the alusrc mux.
  - Register 0 is never forwarded.
- Undefined: res_valid/res_dest/res_data are ignored; ports remain present.

Test Plan:
1. Reset, then offer aluop=10, funct=100010, rs=7, rt=3, alusrc=0, out_ready=1 -> next cycle out_valid=1, alu_a=7, alu_b=3, alu_op=011.
2. aluop=00, alusrc=1, imm=16'hFFFC -> alu_b=32'hFFFFFFFC; aluop=11, imm=16'hFFFC -> alu_b=32'h0000FFFC, alu_op=010.
3. out_ready=0, offer three back-to-back instructions (slt, and, or) -> in_ready=0 after the second is accepted; release out_ready -> outputs 111, 100, 010 in order, none lost.
4. aluop=10, funct=000000 -> illegal=1, alu_op=000; the next legal instruction -> illegal=0.
5. FULL state, assert flush for one cycle with in_valid=1 -> out_valid=0 and in_ready=1 next cycle; the flushed and offered entries never appear.
6. ALU_ISSUE_FORWARD_EN defined: rs_addr=5, res_valid=1, res_dest=5, res_data=99, rs_val=1 -> alu_a=99; repeat with res_dest=0 -> alu_a=1.
